// File: rtl/adc_spi_capture_if.sv
// Pin/sample bundle between adc_spi_capture and its neighbours: ADC serial pins
// plus the converted sample stream handed to the filter chain.
interface adc_spi_capture_if #(
  parameter int NF = 25
);
  logic          run;
  logic          sdata;
  logic          sclk;
  logic          cs_n;
  logic [NF-1:0] Data_Out;
  logic          sample_valid;
  logic          overrun;

  modport master (
    input  run, sdata,
    output sclk, cs_n, Data_Out, sample_valid, overrun
  );

  modport slave (
    output run, sdata,
    input  sclk, cs_n, Data_Out, sample_valid, overrun
  );
endinterface

// File: rtl/adc_spi_capture.sv
// Serial 12-bit ADC front end: periodic CS-framed 16-SCLK read, offset-binary to
// signed fixed point, one-cycle sample strobe that advances the filter chain.
module adc_spi_capture #(
  parameter int NF         = 25,
  parameter int MagnitudF  = 8,
  parameter int DecimalF   = 16,
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 100
)(
  input  logic             clock_In,
  input  logic             Reset,
  adc_spi_capture_if.master bus
);
  localparam int HW = $clog2(2*CLK_DIV) + 1;
  localparam int TW = $clog2(SAMPLE_DIV) + 1;
  localparam int SH = DecimalF - 11;
  localparam int FW = (1 + MagnitudF + DecimalF > NF) ? (1 + MagnitudF + DecimalF) : NF;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_tcnt;
  logic [HW-1:0]   r_hcnt;
  logic [4:0]      r_bcnt;
  // Only the last 12 of the 16 shifted bits are kept; the leading zeros fall off.
  logic [11:0]     r_shift;
  logic            r_sclk, r_cs_n, r_valid, r_ovr;
  logic [NF-1:0]   r_dout;

  logic            w_tick, w_half, w_last, w_quiet_end;
  logic [11:0]     w_s;
  logic [FW-1:0]   w_ext, w_conv;

  assign w_tick      = bus.run && (r_tcnt == TW'(SAMPLE_DIV-1));
  assign w_half      = (r_hcnt == HW'(CLK_DIV-1));
  assign w_last      = (r_bcnt == 5'd16);
  assign w_quiet_end = (r_hcnt == HW'(2*CLK_DIV-1));

  // raw - 2048 is just the MSB inverted
  assign w_s    = {~r_shift[11], r_shift[10:0]};
  assign w_ext  = {{(FW-12){w_s[11]}}, w_s};
  assign w_conv = w_ext << SH;

  always_ff @(posedge clock_In or negedge Reset) begin
    if (!Reset)                  r_tcnt <= '0;
    else if (!bus.run || w_tick) r_tcnt <= '0;
    else                         r_tcnt <= r_tcnt + TW'(1);
  end

  always_ff @(posedge clock_In or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_tick)      w_next = SHIFT;
      SHIFT:   if (w_last)      w_next = DONE;
      DONE:                     w_next = QUIET;
      QUIET:   if (w_quiet_end) w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_In or negedge Reset) begin
    if (!Reset) begin
      r_sclk  <= 1'b1;
      r_cs_n  <= 1'b1;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_dout  <= '0;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick && r_state != IDLE) r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (w_tick) begin
          r_cs_n <= 1'b0;
          r_sclk <= 1'b1;
          r_hcnt <= '0;
          r_bcnt <= '0;
        end
        SHIFT: begin
          // sclk is frozen high once all 16 bits are in, even when CLK_DIV=1
          if (w_last) begin
            r_cs_n  <= 1'b1;
            r_valid <= 1'b1;
            r_dout  <= w_conv[NF-1:0];
            r_hcnt  <= '0;
          end else if (w_half) begin
            r_hcnt <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              r_shift <= {r_shift[10:0], bus.sdata};
              r_bcnt  <= r_bcnt + 5'd1;
            end
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end
        DONE:    r_hcnt <= '0;
        QUIET:   r_hcnt <= r_hcnt + HW'(1);
        default: ;
      endcase
    end
  end

  assign bus.sclk         = r_sclk;
  assign bus.cs_n         = r_cs_n;
  assign bus.Data_Out     = r_dout;
  assign bus.sample_valid = r_valid;
  assign bus.overrun      = r_ovr;
endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench: three capture instances (defaults, SAMPLE_DIV=50, CLK_DIV=1),
// each fed by a small behavioural serial ADC.
module tb_adc_spi_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;

  logic        run_v  [3];
  logic [11:0] raw_v  [3];
  logic        cs_w   [3];
  logic        sclk_w [3];
  logic        vld_w  [3];
  logic        ov_w   [3];
  logic [24:0] dout_w [3];

  logic [11:0] raws2 [3] = '{12'h000, 12'h800, 12'h801};
  logic [24:0] exps2 [3] = '{25'h1FF0000, 25'h0000000, 25'h0000020};

  adc_spi_capture_if #(.NF(25)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic        sd  = 1'b0;
    int          idx = 15;
    logic [15:0] frm;
    assign bus[g].run   = run_v[g];
    assign bus[g].sdata = sd;
    assign cs_w[g]   = bus[g].cs_n;
    assign sclk_w[g] = bus[g].sclk;
    assign vld_w[g]  = bus[g].sample_valid;
    assign ov_w[g]   = bus[g].overrun;
    assign dout_w[g] = bus[g].Data_Out;
    // ADC: new frame on CS fall (sclk is high then); next bit on each sclk fall
    always @(negedge cs_w[g] or negedge sclk_w[g]) begin
      if (sclk_w[g]) idx = 15;
      else if (!cs_w[g] && idx >= 0) begin
        frm = {4'h0, raw_v[g]};
        sd  = frm[idx];
        idx--;
      end
    end
  end

  adc_spi_capture #(.NF(25), .MagnitudF(8), .DecimalF(16), .CLK_DIV(2), .SAMPLE_DIV(100))
    u_a (.clock_In(clk), .Reset(rst_n), .bus(bus[0]));
  adc_spi_capture #(.NF(25), .MagnitudF(8), .DecimalF(16), .CLK_DIV(2), .SAMPLE_DIV(50))
    u_b (.clock_In(clk), .Reset(rst_n), .bus(bus[1]));
  adc_spi_capture #(.NF(25), .MagnitudF(8), .DecimalF(16), .CLK_DIV(1), .SAMPLE_DIV(100))
    u_c (.clock_In(clk), .Reset(rst_n), .bus(bus[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for CS to fall, then watches one full busy window.
  // Cycle index i=0 is the first cycle with cs_n low.
  task automatic frame(input int g, output int tcs, output int pv, output int rises,
                       output int t1, output int t16, output int tv, output int vc,
                       output logic cs16, output logic [24:0] dout);
    int   c;
    logic ps;
    c = (g == 2) ? 1 : 2;
    tcs = 0; pv = 0; rises = 0; t1 = -1; t16 = -1; tv = -1; vc = 0;
    cs16 = 1'b1; dout = '0;
    while (cs_w[g] && tcs < 300) begin
      @(negedge clk);
      tcs++;
      if (vld_w[g]) pv++;
    end
    ps = sclk_w[g];
    for (int i = 1; i <= 34*c + 1; i++) begin
      @(negedge clk);
      if (!ps && sclk_w[g]) begin
        rises++;
        if (rises == 1)  t1 = i;
        if (rises == 16) begin t16 = i; cs16 = cs_w[g]; end
      end
      ps = sclk_w[g];
      if (vld_w[g]) begin
        vc++;
        if (tv < 0) begin tv = i; dout = dout_w[g]; end
      end
    end
  endtask

  initial begin
    int          tcs, pv, rises, t1, t16, tv, vc;
    logic        cs16;
    logic [24:0] dout;
    int          n, pulses, bad_sp, last_v, csf, csf_after, bad_ov, bad_d, first_cs;
    logic        pcs;

    for (int i = 0; i < 3; i++) begin run_v[i] = 1'b0; raw_v[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",  sclk_w[0], 1);
    chk("rst_cs_n",  cs_w[0],   1);
    chk("rst_dout",  dout_w[0], 0);
    chk("rst_vld",   vld_w[0],  0);
    chk("rst_ovr",   ov_w[0],   0);
    rst_n = 1'b1;

    // full-scale positive code
    raw_v[0] = 12'hFFF;
    run_v[0] = 1'b1;
    frame(0, tcs, pv, rises, t1, t16, tv, vc, cs16, dout);
    chk("t1_cs_latency", tcs, 100);
    chk("t1_rises", rises, 16);
    chk("t1_first_rise", t1, 4);
    chk("t1_rise16", t16, 64);
    chk("t1_cs_low_at_rise16", cs16, 0);
    chk("t1_valid_at", tv, 65);
    chk("t1_valid_cnt", vc, 1);
    chk("t1_data", dout, 25'h000FFE0);

    // extremes and mid-scale, back to back at 100-cycle spacing
    for (int k = 0; k < 3; k++) begin
      raw_v[0] = raws2[k];
      frame(0, tcs, pv, rises, t1, t16, tv, vc, cs16, dout);
      chk("t2_cs_spacing", tcs, 31);
      chk("t2_valid_cnt", vc, 1);
      chk("t2_data", dout, exps2[k]);
    end

    // steady stream, then stop mid-conversion
    run_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    run_v[0] = 1'b1;
    pulses = 0; bad_sp = 0; last_v = 0; csf = 0; csf_after = 0;
    pcs = cs_w[0];
    for (n = 1; n <= 1200; n++) begin
      @(negedge clk);
      if (pcs && !cs_w[0]) begin csf++; if (n > 1000) csf_after++; end
      pcs = cs_w[0];
      if (vld_w[0]) begin
        pulses++;
        if (last_v > 0 && n - last_v != 100) bad_sp++;
        last_v = n;
      end
      if (n == 1000) begin
        chk("t3_inflight_at_stop", cs_w[0], 0);
        run_v[0] = 1'b0;
      end
    end
    chk("t3_pulses", pulses, 10);
    chk("t3_bad_spacing", bad_sp, 0);
    chk("t3_last_pulse", last_v, 1065);
    chk("t3_cs_falls", csf, 10);
    chk("t3_cs_falls_after_stop", csf_after, 0);
    chk("t3_no_overrun", ov_w[0], 0);

    // ticks faster than the busy window
    raw_v[1] = 12'h123;
    run_v[1] = 1'b1;
    bad_ov = 0; bad_d = 0; vc = 0; csf = 0; first_cs = 0;
    pcs = cs_w[1];
    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (pcs && !cs_w[1]) begin csf++; if (first_cs == 0) first_cs = n; end
      pcs = cs_w[1];
      if (n == 99)  chk("t4_ovr_before", ov_w[1], 0);
      if (n == 100) chk("t4_ovr_rise", ov_w[1], 1);
      if (n > 100 && !ov_w[1]) bad_ov++;
      if (vld_w[1]) begin
        vc++;
        if (dout_w[1] !== 25'h1FF2460) bad_d++;
      end
    end
    run_v[1] = 1'b0;
    chk("t4_first_cs", first_cs, 50);
    chk("t4_ovr_sticky", bad_ov, 0);
    chk("t4_cs_falls", csf, 4);
    chk("t4_valid_cnt", vc, 3);
    chk("t4_bad_data", bad_d, 0);

    // reset in the middle of a frame
    raw_v[0] = 12'h3C5;
    run_v[0] = 1'b1;
    n = 0;
    while (cs_w[0] && n < 300) begin @(negedge clk); n++; end
    rises = 0;
    pcs = sclk_w[0];
    for (int i = 0; i < 100 && rises < 8; i++) begin
      @(negedge clk);
      if (!pcs && sclk_w[0]) rises++;
      pcs = sclk_w[0];
    end
    chk("t5_rise8_found", rises, 8);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cs_n", cs_w[0], 1);
    chk("t5_rst_sclk", sclk_w[0], 1);
    chk("t5_rst_dout", dout_w[0], 0);
    pv = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (vld_w[0]) pv++; end
    chk("t5_no_vld_in_reset", pv, 0);
    rst_n = 1'b1;
    frame(0, tcs, pv, rises, t1, t16, tv, vc, cs16, dout);
    chk("t5_no_vld_after", pv, 0);
    chk("t5_cs_latency", tcs, 100);
    chk("t5_rises", rises, 16);
    chk("t5_valid_cnt", vc, 1);
    chk("t5_data", dout, 25'h1FF78A0);
    run_v[0] = 1'b0;

    // fastest serial clock
    raw_v[2] = 12'hA5A;
    run_v[2] = 1'b1;
    frame(2, tcs, pv, rises, t1, t16, tv, vc, cs16, dout);
    chk("t6_cs_latency", tcs, 100);
    chk("t6_rises", rises, 16);
    chk("t6_first_rise", t1, 2);
    chk("t6_rise16", t16, 32);
    chk("t6_valid_at", tv, 33);
    chk("t6_valid_cnt", vc, 1);
    chk("t6_data", dout, 25'h0004B40);
    run_v[2] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
